cpu_bus_responder: RTL and testbench

Cache-side protocol engine for CPU bus 1 (A1/D1/C1). It decodes the CPU's two-cycle command/address/data transfer and hands one request to the cache core. It waits for the core's completion, then takes the bus to return C1_RESPONSE and any read data, and releases it. It is the responder counterpart of the CPU initiator driving C1 commands in the testbench, and sits between the tristate bus and the cache datapath.

---
 rtl/cpu_bus_responder_pkg.sv | 55 +++++
 rtl/cpu_bus_responder_c1_bus_driver.sv | 46 ++++
 rtl/cpu_bus_responder.sv | 115 +++++++++++
 tb/tb_cpu_bus_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_responder_pkg.sv
// Shared definitions for the CPU bus 1 responder: bus widths, C1 command codes,
// responder states and small data-shaping helpers.
package cpu_bus_responder_pkg;

  localparam int ADDR1_BUS_SIZE    = 15;
  localparam int DATA1_BUS_SIZE    = 16;
  localparam int CTR1_BUS_SIZE     = 3;
  localparam int CACHE_OFFSET_SIZE = 4;
  localparam int REQ_DATA_W        = 2 * DATA1_BUS_SIZE;
  localparam int REQ_ADDR_W        = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

  localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 3'd0;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 3'd1;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 3'd2;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 3'd3;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 3'd5;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 3'd6;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 3'd7;
  localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_REQ,
    ST_WAIT,
    ST_RESP1,
    ST_RESP2
  } resp_state_e;

  function automatic logic is_read(input logic [CTR1_BUS_SIZE-1:0] cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  // Low write beat, narrowed so bytes above the access size are zero.
  function automatic logic [REQ_DATA_W-1:0] write_lo(input logic [CTR1_BUS_SIZE-1:0] cmd,
                                                     input logic [DATA1_BUS_SIZE-1:0] d);
    case (cmd)
      C1_WRITE8:            return {24'b0, d[7:0]};
      C1_WRITE16, C1_WRITE32: return {16'b0, d};
      default:              return '0;
    endcase
  endfunction

  // Core read data trimmed to the access size, so unused D1 bits go out as 0.
  function automatic logic [REQ_DATA_W-1:0] read_mask(input logic [CTR1_BUS_SIZE-1:0] cmd,
                                                      input logic [REQ_DATA_W-1:0] r);
    case (cmd)
      C1_READ8:  return {24'b0, r[7:0]};
      C1_READ16: return {16'b0, r[15:0]};
      default:   return r;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_responder_c1_bus_driver.sv
// Tristate drive/release of C1 and D1, decoded from the registered responder state.
module c1_bus_driver
  import cpu_bus_responder_pkg::*;
(
  input  resp_state_e                state_i,
  input  logic [CTR1_BUS_SIZE-1:0]   cmd_i,
  input  logic [REQ_DATA_W-1:0]      rdata_i,
  inout  wire  [CTR1_BUS_SIZE-1:0]   c1_io,
  inout  wire  [DATA1_BUS_SIZE-1:0]  d1_io
);

  logic                      c1_en;
  logic [CTR1_BUS_SIZE-1:0]  c1_val;
  logic                      d1_en;
  logic [DATA1_BUS_SIZE-1:0] d1_val;

  always_comb begin
    c1_en  = 1'b0;
    c1_val = C1_NOP;
    d1_en  = 1'b0;
    d1_val = '0;
    case (state_i)
      ST_REQ, ST_WAIT: begin
        c1_en  = 1'b1;
        c1_val = C1_NOP;
      end
      ST_RESP1: begin
        c1_en  = 1'b1;
        c1_val = C1_RESPONSE;
        d1_en  = is_read(cmd_i);
        d1_val = rdata_i[15:0];
      end
      ST_RESP2: begin
        c1_en  = 1'b1;
        c1_val = C1_RESPONSE;
        d1_en  = is_read(cmd_i);
        d1_val = rdata_i[31:16];
      end
      default: ;
    endcase
  end

  assign c1_io = c1_en ? c1_val : {CTR1_BUS_SIZE{1'bz}};
  assign d1_io = d1_en ? d1_val : {DATA1_BUS_SIZE{1'bz}};

endmodule

// File: rtl/cpu_bus_responder.sv
// Responder for CPU bus 1: decodes the two-beat C1 transfer, issues one core request,
// and returns C1_RESPONSE plus read data. Define C1_PROTOCOL_CHECK_EN to add proto_err.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  inout  wire  [ADDR1_BUS_SIZE-1:0]  A1_WIRE,
  inout  wire  [DATA1_BUS_SIZE-1:0]  D1_WIRE,
  inout  wire  [CTR1_BUS_SIZE-1:0]   C1_WIRE,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [CTR1_BUS_SIZE-1:0]   req_cmd,
  output logic [REQ_ADDR_W-1:0]      req_addr,
  output logic [REQ_DATA_W-1:0]      req_wdata,
  input  logic                       resp_valid,
  input  logic [REQ_DATA_W-1:0]      resp_rdata
`ifdef C1_PROTOCOL_CHECK_EN
  , output logic                     proto_err
`endif
);

  resp_state_e               state_q;
  logic                      req_valid_q;
  logic [CTR1_BUS_SIZE-1:0]  cmd_q;
  logic [REQ_ADDR_W-1:0]     addr_q;
  logic [REQ_DATA_W-1:0]     wdata_q;
  logic [REQ_DATA_W-1:0]     rdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      cmd_q       <= C1_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A floating or unknown C1 never compares unequal to NOP as true.
          if (C1_WIRE != C1_NOP) begin
            cmd_q   <= C1_WIRE;
            addr_q  <= {A1_WIRE, {CACHE_OFFSET_SIZE{1'b0}}};
            wdata_q <= write_lo(C1_WIRE, D1_WIRE);
            state_q <= ST_ADDR2;
          end
        end
        ST_ADDR2: begin
          addr_q[CACHE_OFFSET_SIZE-1:0] <= A1_WIRE[CACHE_OFFSET_SIZE-1:0];
          if (cmd_q == C1_WRITE32) wdata_q[31:16] <= D1_WIRE;
          req_valid_q <= 1'b1;
          state_q     <= ST_REQ;
        end
        ST_REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            if (resp_valid) begin
              rdata_q <= read_mask(cmd_q, resp_rdata);
              state_q <= ST_RESP1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            rdata_q <= read_mask(cmd_q, resp_rdata);
            state_q <= ST_RESP1;
          end
        end
        ST_RESP1: state_q <= (cmd_q == C1_READ32) ? ST_RESP2 : ST_IDLE;
        ST_RESP2: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_valid = req_valid_q;
  assign req_cmd   = cmd_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;

  c1_bus_driver u_drv (
    .state_i (state_q),
    .cmd_i   (cmd_q),
    .rdata_i (rdata_q),
    .c1_io   (C1_WIRE),
    .d1_io   (D1_WIRE)
  );

`ifdef C1_PROTOCOL_CHECK_EN
  logic                     proto_err_q;
  logic                     we_drive_c1;
  logic [CTR1_BUS_SIZE-1:0] our_c1;

  assign we_drive_c1 = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                       (state_q == ST_RESP1) || (state_q == ST_RESP2);
  assign our_c1      = ((state_q == ST_RESP1) || (state_q == ST_RESP2)) ? C1_RESPONSE : C1_NOP;

  // Contention shows up as the resolved bus differing from what we put on it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      proto_err_q <= 1'b0;
    end else if ((state_q == ST_ADDR2) && $isunknown(C1_WIRE)) begin
      proto_err_q <= 1'b1;
    end else if (we_drive_c1 && ($isunknown(C1_WIRE) || (C1_WIRE != our_c1))) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder: directed table, randomized transactions
// against a transaction-level model, and reset/contention sequences.
module tb_cpu_bus_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        req_valid;
  logic [2:0]  req_cmd;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
`ifdef C1_PROTOCOL_CHECK_EN
  logic        proto_err;
`endif

  logic [14:0] cpu_a;  logic cpu_a_en;
  logic [15:0] cpu_d;  logic cpu_d_en;
  logic [2:0]  cpu_c;  logic cpu_c_en;
  wire  [14:0] A1_WIRE;
  wire  [15:0] D1_WIRE;
  wire  [2:0]  C1_WIRE;

  assign A1_WIRE = cpu_a_en ? cpu_a : 15'bz;
  assign D1_WIRE = cpu_d_en ? cpu_d : 16'bz;
  assign C1_WIRE = cpu_c_en ? cpu_c : 3'bz;

  logic a1_z, d1_z, c1_z;
  assign a1_z = (A1_WIRE === 15'bzzzzzzzzzzzzzzz);
  assign d1_z = (D1_WIRE === 16'bzzzzzzzzzzzzzzzz);
  assign c1_z = (C1_WIRE === 3'bzzz);

  always #5 CLK = ~CLK;

  cpu_bus_responder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .A1_WIRE    (A1_WIRE),
    .D1_WIRE    (D1_WIRE),
    .C1_WIRE    (C1_WIRE),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
`ifdef C1_PROTOCOL_CHECK_EN
    , .proto_err (proto_err)
`endif
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [14:0] a1;
    logic [14:0] a2;
    logic [15:0] d1a;
    logic [15:0] d1b;
    logic [31:0] rdata;
    int          ready_dly;
    int          resp_dly;
    logic [18:0] exp_addr;
    logic [31:0] exp_wdata;
    int          exp_beats;
    bit          exp_d_z;
    logic [15:0] exp_d [2];
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cmd, input logic [14:0] a1, input logic [14:0] a2,
                              input logic [15:0] d1a, input logic [15:0] d1b, input logic [31:0] rdata,
                              input int rdy, input int rsp, input logic [18:0] ea, input logic [31:0] ew,
                              input int beats, input bit dz, input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.cmd = cmd; v.a1 = a1; v.a2 = a2; v.d1a = d1a; v.d1b = d1b; v.rdata = rdata;
    v.ready_dly = rdy; v.resp_dly = rsp; v.exp_addr = ea; v.exp_wdata = ew;
    v.exp_beats = beats; v.exp_d_z = dz; v.exp_d[0] = e0; v.exp_d[1] = e1;
    return v;
  endfunction

  // Transaction-level expectations from the command rules, in plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint unsigned data;
    r.exp_addr = 19'(longint'(v.a1) * 16 + longint'(v.a2) % 16);
    case (v.cmd)
      3'd5:    r.exp_wdata = 32'(v.d1a % 256);
      3'd6:    r.exp_wdata = 32'(v.d1a);
      3'd7:    r.exp_wdata = 32'(longint'(v.d1b) * 65536 + longint'(v.d1a));
      default: r.exp_wdata = 32'd0;
    endcase
    r.exp_beats = (v.cmd == 3'd3) ? 2 : 1;
    r.exp_d_z   = !(v.cmd >= 3'd1 && v.cmd <= 3'd3);
    data = (v.cmd == 3'd1) ? longint'(v.rdata) % 256 :
           (v.cmd == 3'd2) ? longint'(v.rdata) % 65536 : longint'(v.rdata);
    r.exp_d[0] = 16'(data % 65536);
    r.exp_d[1] = 16'(data / 65536);
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    @(negedge CLK);
    cpu_c = v.cmd; cpu_a = v.a1; cpu_d = v.d1a;
    cpu_c_en = 1'b1; cpu_a_en = 1'b1; cpu_d_en = 1'b1;
    @(negedge CLK);
    cpu_a = v.a2; cpu_d = v.d1b;
    for (int i = 0; i <= v.ready_dly; i++) begin
      @(negedge CLK);
      cpu_c_en = 1'b0; cpu_a_en = 1'b0; cpu_d_en = 1'b0;
      req_ready  = (i == v.ready_dly);
      resp_valid = (i == v.ready_dly) && (v.resp_dly == 0);
      resp_rdata = v.rdata;
      #1;
      chk({tag, " req_valid in REQ"}, 32'(req_valid), 32'd1);
      chk({tag, " C1 NOP in REQ"}, {28'd0, c1_z, C1_WIRE}, 32'd0);
      if (i == 0) begin
        chk({tag, " req_cmd"}, 32'(req_cmd), 32'(v.cmd));
        chk({tag, " req_addr"}, 32'(req_addr), 32'(v.exp_addr));
        chk({tag, " req_wdata"}, req_wdata, v.exp_wdata);
        chk({tag, " D1 released in REQ"}, 32'(d1_z), 32'd1);
      end
    end
    for (int i = 1; i <= v.resp_dly; i++) begin
      @(negedge CLK);
      req_ready  = 1'b0;
      resp_valid = (i == v.resp_dly);
      #1;
      chk({tag, " req_valid in WAIT"}, 32'(req_valid), 32'd0);
      chk({tag, " C1 NOP in WAIT"}, {28'd0, c1_z, C1_WIRE}, 32'd0);
    end
    for (int b = 0; b < v.exp_beats; b++) begin
      @(negedge CLK);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_rdata = ~v.rdata;
      #1;
      chk({tag, " C1 RESPONSE"}, {28'd0, c1_z, C1_WIRE}, 32'd7);
      if (v.exp_d_z) chk({tag, " D1 z in response"}, 32'(d1_z), 32'd1);
      else           chk({tag, " D1 beat"}, {15'd0, d1_z, D1_WIRE}, {16'd0, v.exp_d[b]});
    end
    @(negedge CLK);
    resp_valid = 1'b0;
    #1;
    chk({tag, " C1 released"}, 32'(c1_z), 32'd1);
    chk({tag, " D1 released"}, 32'(d1_z), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl [7];
  vec_t rv;

  initial begin
    RESET = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    cpu_a = '0; cpu_d = '0; cpu_c = '0;
    cpu_a_en = 1'b0; cpu_d_en = 1'b0; cpu_c_en = 1'b0;

    tbl[0] = mk(3'd4, 15'd1, 15'd2, 16'h5A5A, 16'hA5A5, 32'h0, 0, 1,
                19'h00012, 32'h0, 1, 1'b1, 16'h0, 16'h0);
    tbl[1] = mk(3'd3, 15'h1ABC, 15'h0005, 16'h0, 16'h0, 32'hDEADBEEF, 0, 0,
                19'h1ABC5, 32'h0, 2, 1'b0, 16'hBEEF, 16'hDEAD);
    tbl[2] = mk(3'd7, 15'h7FFF, 15'h7FF3, 16'h1234, 16'hABCD, 32'h0, 0, 2,
                19'h7FFF3, 32'hABCD1234, 1, 1'b1, 16'h0, 16'h0);
    tbl[3] = mk(3'd2, 15'h0040, 15'h000F, 16'h0, 16'h0, 32'h5555A5C3, 5, 1,
                19'h0040F, 32'h0, 1, 1'b0, 16'hA5C3, 16'h0);
    tbl[4] = mk(3'd1, 15'h2000, 15'h1238, 16'h0, 16'h0, 32'h123456F0, 1, 0,
                19'h20008, 32'h0, 1, 1'b0, 16'h00F0, 16'h0);
    tbl[5] = mk(3'd5, 15'h0003, 15'h0001, 16'hBEEF, 16'h7777, 32'h0, 0, 0,
                19'h00031, 32'h000000EF, 1, 1'b1, 16'h0, 16'h0);
    tbl[6] = mk(3'd6, 15'h0100, 15'h000A, 16'hCAFE, 16'h1111, 32'h0, 2, 3,
                19'h0100A, 32'h0000CAFE, 1, 1'b1, 16'h0, 16'h0);

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("reset req_valid", 32'(req_valid), 32'd0);
    chk("reset req_cmd", 32'(req_cmd), 32'd0);
    chk("reset req_addr", 32'(req_addr), 32'd0);
    chk("reset req_wdata", req_wdata, 32'd0);
    chk("reset C1 z", 32'(c1_z), 32'd1);
    chk("reset D1 z", 32'(d1_z), 32'd1);
    chk("reset A1 z", 32'(a1_z), 32'd1);
`ifdef C1_PROTOCOL_CHECK_EN
    chk("reset proto_err", 32'(proto_err), 32'd0);
`endif

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 40; n++) begin
      rv = mk(3'($urandom_range(1, 7)), 15'($urandom), 15'($urandom), 16'($urandom), 16'($urandom),
              32'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              19'd0, 32'd0, 1, 1'b0, 16'h0, 16'h0);
      run_txn(model(rv), $sformatf("rnd%0d", n));
    end

    // RESET while waiting on the core, then a late core response must be dropped.
    @(negedge CLK);
    cpu_c = 3'd2; cpu_a = 15'h0ABC; cpu_d = 16'h0;
    cpu_c_en = 1'b1; cpu_a_en = 1'b1; cpu_d_en = 1'b1;
    @(negedge CLK);
    cpu_a = 15'h0007;
    @(negedge CLK);
    cpu_c_en = 1'b0; cpu_a_en = 1'b0; cpu_d_en = 1'b0;
    req_ready = 1'b1;
    @(negedge CLK);
    req_ready = 1'b0;
    #1;
    chk("rstwait C1 NOP", {28'd0, c1_z, C1_WIRE}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h87654321;
    #1;
    chk("rstwait C1 z", 32'(c1_z), 32'd1);
    chk("rstwait req_valid", 32'(req_valid), 32'd0);
    chk("rstwait req_addr", 32'(req_addr), 32'd0);
    chk("rstwait req_cmd", 32'(req_cmd), 32'd0);
    @(negedge CLK);
    resp_valid = 1'b0;
    #1;
    chk("rstwait dropped resp C1 z", 32'(c1_z), 32'd1);
    chk("rstwait dropped resp D1 z", 32'(d1_z), 32'd1);
    run_txn(mk(3'd1, 15'h0055, 15'h0003, 16'h0, 16'h0, 32'hFFFF_FF81, 0, 1,
               19'h00553, 32'h0, 1, 1'b0, 16'h0081, 16'h0), "postrst");

`ifdef C1_PROTOCOL_CHECK_EN
    chk("proto_err clean run", 32'(proto_err), 32'd0);
    @(negedge CLK);
    cpu_c = 3'd1; cpu_a = 15'h0011; cpu_d = 16'h0;
    cpu_c_en = 1'b1; cpu_a_en = 1'b1; cpu_d_en = 1'b1;
    @(negedge CLK);
    cpu_a = 15'h0001;
    @(negedge CLK);
    cpu_c_en = 1'b0; cpu_a_en = 1'b0; cpu_d_en = 1'b0;
    req_ready = 1'b1;
    @(negedge CLK);
    req_ready = 1'b0;
    cpu_c = 3'd1; cpu_c_en = 1'b1;
    @(negedge CLK);
    cpu_c_en = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h0;
    #1;
    chk("proto_err contention", 32'(proto_err), 32'd1);
    @(negedge CLK);
    resp_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("proto_err sticky", 32'(proto_err), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("proto_err cleared", 32'(proto_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
